// File: rtl/jsv_pkg.sv
// Shared definitions for the SDRAM pixel writer/fetcher pair: frame geometry
// defaults, iteration-count width and fetch FSM state encodings.
package jsv_pkg;
    localparam int H_RES_DEF  = 640;
    localparam int V_RES_DEF  = 480;
    localparam int ADDR_W_DEF = 19;
    localparam int ITER_W     = 8;

    typedef logic [2:0] fetch_state_t;

    localparam fetch_state_t ST_IDLE  = 3'd0;
    localparam fetch_state_t ST_LOAD  = 3'd1;
    localparam fetch_state_t ST_ISSUE = 3'd2;
    localparam fetch_state_t ST_WAIT  = 3'd3;
    localparam fetch_state_t ST_DONE  = 3'd4;
endpackage

// File: rtl/line_buf_dp.sv
// Ping-pong line store: write port fills {bank,x}, read port is a registered
// read of {bank,x}; no reset so it maps onto block RAM.
module line_buf_dp
    import jsv_pkg::*;
#(
    parameter int X_W = 10
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [X_W:0]      i_wr_addr,
    input  logic [ITER_W-1:0] i_wr_dat,
    input  logic [X_W:0]      i_rd_addr,
    output logic [ITER_W-1:0] o_rd_dat
);
    // Depth is a power of two so {bank,x} addresses directly without an adder.
    logic [ITER_W-1:0] r_mem [0:(2**(X_W+1))-1];
    logic [ITER_W-1:0] r_rd_dat;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
        r_rd_dat <= r_mem[i_rd_addr];
    end

    assign o_rd_dat = r_rd_dat;
endmodule

// File: rtl/sdram_line_fetcher.sv
// Fetches one scanline of iteration counts per line_start over the bridge read
// port into the back bank of a ping-pong buffer; the pixel path reads the front.
module sdram_line_fetcher
    import jsv_pkg::*;
#(
    parameter int H_RES     = H_RES_DEF,
    parameter int V_RES     = V_RES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int BASE_ADDR = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_line_start,
    input  logic [9:0]        i_fetch_line,
    input  logic [9:0]        i_pix_x,
    output logic [ITER_W-1:0] o_pix_iter,
    output logic [ADDR_W-1:0] o_br_address,
    output logic              o_br_read,
    output logic [1:0]        o_br_byte_en,
    input  logic              i_br_ack,
    input  logic [15:0]       i_br_rdata,
    output logic              o_fetch_busy,
    output logic              o_underrun
);
    localparam int         X_W    = 10;
    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [9:0] X_LIM  = 10'(H_RES);
    localparam logic [9:0] V_LIM  = 10'(V_RES);

    if ((BASE_ADDR + H_RES * V_RES > 2 ** ADDR_W) || (H_RES > 1024) || (V_RES > 1023)) begin : g_bad_geometry
        $error("sdram_line_fetcher: frame does not fit the address or index widths");
    end

    fetch_state_t      r_state;
    logic              r_front;
    logic [1:0]        r_valid;
    logic [X_W-1:0]    r_x;
    logic [9:0]        r_fetch_line;
    logic [ADDR_W-1:0] r_line_base;
    logic              r_br_read;
    logic [ADDR_W-1:0] r_br_address;
    logic              r_underrun;
    logic              r_pix_ok;

    logic              w_busy;
    logic              w_wr_en;
    logic              w_final_ack;
    logic [ITER_W-1:0] w_rd_dat;
    logic              w_unused_rdata;

    assign w_busy      = (r_state == ST_LOAD) || (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign w_wr_en     = (r_state == ST_WAIT) && i_br_ack;
    assign w_final_ack = w_wr_en && (r_x == X_LAST);
    assign w_unused_rdata = &{1'b0, i_br_rdata[15:ITER_W]};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_front      <= 1'b0;
            r_valid      <= 2'b00;
            r_x          <= '0;
            r_fetch_line <= '0;
            r_line_base  <= '0;
            r_br_read    <= 1'b0;
            r_br_address <= '0;
            r_underrun   <= 1'b0;
            r_pix_ok     <= 1'b0;
        end else begin
            r_pix_ok <= r_valid[r_front] && (i_pix_x < X_LIM);
            if (w_final_ack) begin
                r_valid[~r_front] <= 1'b1;
            end
            // A swap always hands the old front to the filler, so it loses validity.
            if (i_line_start) begin
                r_front          <= ~r_front;
                r_valid[r_front] <= 1'b0;
                r_fetch_line     <= i_fetch_line;
                r_br_read        <= 1'b0;
                r_state          <= ST_LOAD;
                if (w_busy && !w_final_ack) begin
                    r_underrun <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        r_line_base <= ADDR_W'(BASE_ADDR) + ADDR_W'(r_fetch_line) * ADDR_W'(H_RES);
                        r_x         <= '0;
                        r_state     <= (r_fetch_line >= V_LIM) ? ST_DONE : ST_ISSUE;
                    end
                    ST_ISSUE: begin
                        r_br_read    <= 1'b1;
                        r_br_address <= r_line_base + ADDR_W'(r_x);
                        r_state      <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (i_br_ack) begin
                            r_br_read <= 1'b0;
                            if (r_x == X_LAST) begin
                                r_state <= ST_DONE;
                            end else begin
                                r_x     <= r_x + 1'b1;
                                r_state <= ST_ISSUE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    line_buf_dp #(.X_W(X_W)) u_line_buf (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr ({~r_front, r_x}),
        .i_wr_dat  (i_br_rdata[ITER_W-1:0]),
        .i_rd_addr ({r_front, i_pix_x}),
        .o_rd_dat  (w_rd_dat)
    );

    assign o_pix_iter   = r_pix_ok ? w_rd_dat : '0;
    assign o_br_address = r_br_address;
    assign o_br_read    = r_br_read;
    assign o_br_byte_en = 2'b01;
    assign o_fetch_busy = w_busy;
    assign o_underrun   = r_underrun;
endmodule

// File: tb/tb_sdram_line_fetcher.sv
// Bench: bridge responder with programmable ack latency, scanline scoreboard
// and a line-level model of which fetched line is on display.
module tb_sdram_line_fetcher;
    localparam int HR = 640;
    localparam int VR = 480;
    localparam int BASE_B = 'h100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        line_start = 1'b0;
    logic [9:0]  fetch_line = '0;
    logic [9:0]  pix_x = '0;
    logic        br_ack = 1'b0;
    logic [15:0] br_rdata = '0;

    logic [7:0]  pix_iter_a;
    logic [18:0] br_addr_a;
    logic        br_read_a;
    logic [1:0]  byte_en_a;
    logic        busy_a;
    logic        underrun_a;

    logic [7:0]  pix_iter_b_unused;
    logic [18:0] br_addr_b;
    logic        br_read_b_unused;
    logic [1:0]  byte_en_b_unused;
    logic        busy_b_unused;
    logic        underrun_b_unused;

    int n_checks = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    sdram_line_fetcher #(.H_RES(HR), .V_RES(VR), .ADDR_W(19), .BASE_ADDR(0)) u_dut (
        .i_clk(clk), .i_reset(reset), .i_line_start(line_start), .i_fetch_line(fetch_line),
        .i_pix_x(pix_x), .o_pix_iter(pix_iter_a), .o_br_address(br_addr_a), .o_br_read(br_read_a),
        .o_br_byte_en(byte_en_a), .i_br_ack(br_ack), .i_br_rdata(br_rdata),
        .o_fetch_busy(busy_a), .o_underrun(underrun_a)
    );

    sdram_line_fetcher #(.H_RES(HR), .V_RES(VR), .ADDR_W(19), .BASE_ADDR(BASE_B)) u_dut_b (
        .i_clk(clk), .i_reset(reset), .i_line_start(line_start), .i_fetch_line(fetch_line),
        .i_pix_x(pix_x), .o_pix_iter(pix_iter_b_unused), .o_br_address(br_addr_b),
        .o_br_read(br_read_b_unused), .o_br_byte_en(byte_en_b_unused), .i_br_ack(br_ack),
        .i_br_rdata(br_rdata), .o_fetch_busy(busy_b_unused), .o_underrun(underrun_b_unused)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Scanline scoreboard: x advances on every accepted ack, restarts on line_start.
    int t_x = 0;
    int t_base = 0;
    int t_acks = 0;
    always @(posedge clk) begin
        if (reset) begin
            t_x = 0;
            t_acks = 0;
        end else if (line_start) begin
            t_x = 0;
            t_acks = 0;
            t_base = int'(fetch_line) * HR;
        end else if (br_read_a && br_ack) begin
            t_x++;
            t_acks++;
        end
    end

    // Bridge responder: acks after lat wait cycles, data low byte = address+1.
    int   lat = 0;
    int   wcnt = 0;
    bit   have_req = 0;
    int   req_addr = 0;
    int   n_reads = 0;
    int   first_addr_b = -1;
    always @(negedge clk) begin
        if (reset) begin
            br_ack = 1'b0;
            have_req = 0;
        end else if (br_ack) begin
            check("read_drop_after_ack", 32'(br_read_a), 32'd0);
            br_ack = 1'b0;
            have_req = 0;
        end else if (!br_read_a) begin
            have_req = 0;
        end else begin
            if (!have_req) begin
                check("rd_addr", 32'(br_addr_a), 32'(t_base + t_x));
                check("rd_addr_base100", 32'(br_addr_b), 32'(BASE_B + t_base + t_x));
                if (t_x == 0) first_addr_b = int'(br_addr_b);
                have_req = 1;
                req_addr = int'(br_addr_a);
                wcnt = 0;
                n_reads++;
            end else begin
                check("addr_stable", 32'(br_addr_a), 32'(req_addr));
            end
            if (wcnt >= lat) begin
                br_ack = 1'b1;
                br_rdata = {8'($urandom), 8'(br_addr_a + 19'd1)};
            end else begin
                wcnt++;
            end
        end
    end

    // Display model: which line sits in the front bank and whether it is complete.
    bit m_front_ok = 0;
    int m_front_line = -1;
    int m_back_line = -1;

    function automatic int exp_pix(input int px);
        if (!m_front_ok || px >= HR) return 0;
        return (m_front_line * HR + px + 1) % 256;
    endfunction

    function automatic void model_swap(input int line, input bit back_done);
        m_front_ok = back_done && (m_back_line >= 0) && (m_back_line < VR);
        m_front_line = m_back_line;
        m_back_line = line;
    endfunction

    task automatic do_line_start(input int line, input bit back_done);
        @(negedge clk);
        fetch_line = 10'(line);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        model_swap(line, back_done);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy_a && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(busy_a), 32'd0);
    endtask

    task automatic check_pix(input int px, input int expv, input string nm);
        pix_x = 10'(px);
        @(posedge clk);
        #1;
        check(nm, 32'(pix_iter_a), 32'(expv));
        @(negedge clk);
    endtask

    task automatic rand_pix(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            int px;
            px = int'($urandom_range(0, 700));
            check_pix(px, exp_pix(px), $sformatf("%s_x%0d", nm, px));
        end
    endtask

    typedef struct {
        int px;
        int exp;
    } pix_vec_t;

    initial begin
        pix_vec_t tbl[8];
        int n;
        int reads0;
        tbl[0] = '{0, 1};     tbl[1] = '{5, 6};     tbl[2] = '{100, 101};
        tbl[3] = '{254, 255}; tbl[4] = '{255, 0};   tbl[5] = '{639, 128};
        tbl[6] = '{640, 0};   tbl[7] = '{1023, 0};

        repeat (3) @(negedge clk);
        check("rst_pix_iter", 32'(pix_iter_a), 32'd0);
        check("rst_br_read", 32'(br_read_a), 32'd0);
        check("rst_br_addr", 32'(br_addr_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_underrun", 32'(underrun_a), 32'd0);
        check("byte_en", 32'(byte_en_a), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // 1: single-cycle acks, full line 0, then display it.
        lat = 0;
        do_line_start(0, 0);
        check("t1_busy_rises", 32'(busy_a), 32'd1);
        wait_idle("t1_busy_falls");
        check("t1_read_count", 32'(t_acks), 32'd640);
        lat = int'($urandom_range(0, 2));
        do_line_start(1, 1);
        for (int i = 0; i < 8; i++)
            check_pix(tbl[i].px, tbl[i].exp, $sformatf("t1_tbl%0d_x%0d", i, tbl[i].px));
        wait_idle("t1_line1_done");

        // 2: three wait cycles per read; responder checks address stability.
        lat = 3;
        do_line_start(2, 1);
        rand_pix(10, "t2_line1");
        wait_idle("t2_done");
        check("t2_read_count", 32'(t_acks), 32'd640);

        // 3: last visible line on the offset instance, then a blank line.
        lat = int'($urandom_range(0, 2));
        do_line_start(479, 1);
        rand_pix(8, "t3_line2");
        wait_idle("t3_done");
        check("t3_first_addr_b", 32'(first_addr_b), 32'(BASE_B + 479 * HR));
        do_line_start(480, 1);
        reads0 = n_reads;
        rand_pix(8, "t3_line479");
        repeat (30) @(negedge clk);
        check("t3_blank_no_reads", 32'(n_reads - reads0), 32'd0);
        check("t3_blank_not_busy", 32'(busy_a), 32'd0);
        do_line_start(3, 1);
        check_pix(10, 0, "t3_blank_x10");
        rand_pix(6, "t3_blank");
        check("t3_no_underrun", 32'(underrun_a), 32'd0);
        wait_idle("t3_line3_done");

        // 4: swap mid-fill at x=300.
        lat = int'($urandom_range(0, 2));
        do_line_start(4, 1);
        n = 0;
        while (t_x < 300 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("t4_reach_x300", 32'(t_x >= 300), 32'd1);
        do_line_start(5, 0);
        check("t4_underrun_set", 32'(underrun_a), 32'd1);
        check_pix(0, 0, "t4_partial_x0");
        check_pix(50, 0, "t4_partial_x50");
        rand_pix(4, "t4_partial");
        wait_idle("t4_refetch_done");
        check("t4_refetch_count", 32'(t_acks), 32'd640);
        do_line_start(6, 1);
        rand_pix(6, "t4_line5");
        check("t4_underrun_sticky", 32'(underrun_a), 32'd1);

        // Reset clears the sticky flag and both banks.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_front_ok = 0;
        m_front_line = -1;
        m_back_line = -1;
        check("t4_underrun_cleared", 32'(underrun_a), 32'd0);

        // 5: line_start on the final ack.
        lat = 1;
        do_line_start(7, 0);
        n = 0;
        while (!(br_ack && t_x == 639) && n < 10000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("t5_final_ack_seen", 32'(br_ack && t_x == 639), 32'd1);
        fetch_line = 10'd8;
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        model_swap(8, 1);
        check("t5_no_underrun", 32'(underrun_a), 32'd0);
        check_pix(639, (7 * HR + 640) % 256, "t5_last_pixel");
        rand_pix(8, "t5_line7");
        wait_idle("t5_line8_done");

        // 6: reset in the middle of a read.
        lat = 3;
        do_line_start(9, 1);
        n = 0;
        while (!br_read_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_in_wait", 32'(br_read_a), 32'd1);
        pix_x = 10'd20;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t6_br_read", 32'(br_read_a), 32'd0);
        check("t6_busy", 32'(busy_a), 32'd0);
        check("t6_pix_iter", 32'(pix_iter_a), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
